// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//
// Periodic multi-channel sampling scheduler in front of the 8-bit ADC
// control block. Each period tick starts a scan of the enabled mux channels
// in ascending order. Each channel gets a settle wait, a single conversion
// request and a bounded wait for the result. Results are tagged with their
// channel and queued in a show-ahead FIFO for the downstream stream port.
//
// Ports
//   clk_100M     system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       scheduler enable
//   ch_mask      per-channel enable, bit i = channel i
//   period       scan-start interval in cycles (0 behaves as 1)
//   clr_err      clears the sticky error flags
//   mux_sel      analog mux channel select (holds between scans)
//   adc_start    one-cycle conversion request
//   adc_ready    one-cycle result strobe, adc_data valid
//   adc_data     conversion result
//   smp_valid    FIFO head valid
//   smp_ready    downstream accept
//   smp_data     FIFO head sample
//   smp_ch       FIFO head channel tag
//   busy         scan in progress
//   overflow     sticky: sample dropped on a full FIFO
//   timeout_err  sticky: conversion timed out
//   overrun      sticky: period tick arrived during a scan
//
// State      | meaning
// -----------+------------------------------------------------------------
// IDLE       | scheduler disabled
// WAIT_TICK  | enabled, waiting for the next period tick
// SELECT     | mux_sel driven, settle countdown running
// START      | adc_start asserted for this single cycle
// WAIT_CONV  | waiting for adc_ready, timeout countdown running
// NEXT       | pick next channel of the latched mask, or end the scan

module adc_scan_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int PERIOD_W       = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk_100M,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clr_err,
    output logic [CH_W-1:0]     mux_sel,
    output logic                adc_start,
    input  logic                adc_ready,
    input  logic [7:0]          adc_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [7:0]          smp_data,
    output logic [CH_W-1:0]     smp_ch,
    output logic                busy,
    output logic                overflow,
    output logic                timeout_err,
    output logic                overrun
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENT_W   = CH_W + 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_SELECT,
        S_START,
        S_WAIT_CONV,
        S_NEXT
    } state_t;

    // ------------------------------------------------------------------
    // Period timer
    // ------------------------------------------------------------------
    // tmr_live is clear out of reset so the timer reads as the reload value
    // without needing an asynchronous load from the period input.
    logic [PERIOD_W-1:0] tmr_cnt;
    logic [PERIOD_W-1:0] tmr_cur;
    logic [PERIOD_W-1:0] tmr_reload;
    logic                tmr_live;
    logic                tick;

    always_comb begin
        tmr_reload = (period == '0) ? '0 : period - PERIOD_W'(1);
        tmr_cur    = tmr_live ? tmr_cnt : tmr_reload;
        tick       = enable && (tmr_cur == '0);
    end

    always_ff @(posedge clk_100M or negedge reset) begin
        if (!reset) begin
            tmr_cnt  <= '0;
            tmr_live <= 1'b0;
        end else begin
            tmr_live <= 1'b1;
            if (!enable || tick) begin
                tmr_cnt <= tmr_reload;
            end else begin
                tmr_cnt <= tmr_cur - PERIOD_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_ch = CH_W'(i);
            end
        end
    endfunction

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [NUM_CH-1:0] scan_mask, scan_mask_nxt;
    logic [CH_W-1:0]   ch_q, ch_nxt;
    logic              push_req;
    logic              timeout_set;

    always_ff @(posedge clk_100M or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            scan_mask <= '0;
            ch_q      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            scan_mask <= scan_mask_nxt;
            ch_q      <= ch_nxt;
        end
    end

    // scan_mask holds only the channels still to be visited: each bit is
    // cleared as its channel is selected, so NEXT just takes the lowest one.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        scan_mask_nxt = scan_mask;
        ch_nxt        = ch_q;
        push_req      = 1'b0;
        timeout_set   = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_WAIT_TICK;
                end
            end

            S_WAIT_TICK: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (tick && (ch_mask != '0)) begin
                    ch_nxt        = lowest_ch(ch_mask);
                    scan_mask_nxt = ch_mask & (ch_mask - NUM_CH'(1));
                    cnt_nxt       = CNT_W'(SETTLE_CYCLES - 1);
                    state_nxt     = S_SELECT;
                end
            end

            S_SELECT: begin
                if (cnt == '0) begin
                    state_nxt = S_START;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_START: begin
                cnt_nxt   = CNT_W'(TIMEOUT_CYCLES - 1);
                state_nxt = S_WAIT_CONV;
            end

            S_WAIT_CONV: begin
                // A result arriving in the last allowed cycle still counts.
                if (adc_ready) begin
                    push_req  = 1'b1;
                    state_nxt = S_NEXT;
                end else if (cnt == '0) begin
                    timeout_set = 1'b1;
                    state_nxt   = S_NEXT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            S_NEXT: begin
                if (scan_mask != '0) begin
                    ch_nxt        = lowest_ch(scan_mask);
                    scan_mask_nxt = scan_mask & (scan_mask - NUM_CH'(1));
                    cnt_nxt       = CNT_W'(SETTLE_CYCLES - 1);
                    state_nxt     = S_SELECT;
                end else if (enable) begin
                    state_nxt = S_WAIT_TICK;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign mux_sel   = ch_q;
    assign adc_start = (state == S_START);
    assign busy      = (state == S_SELECT) || (state == S_START) ||
                       (state == S_WAIT_CONV) || (state == S_NEXT);

    // ------------------------------------------------------------------
    // Sample FIFO (show-ahead)
    // ------------------------------------------------------------------
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             ovf_set;
    logic [ENT_W-1:0] head;

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop        = !fifo_empty && smp_ready;
        // A pop in the same cycle frees the slot the push needs.
        push       = push_req && (!fifo_full || pop);
        ovf_set    = push_req && fifo_full && !pop;
        head       = mem[rd_ptr[PTR_W-1:0]];
    end

    always_ff @(posedge clk_100M or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {ch_q, adc_data};
        end
    end

    // Head is gated so the stream outputs read zero whenever nothing is held.
    assign smp_valid = !fifo_empty;
    assign smp_data  = smp_valid ? head[7:0]         : '0;
    assign smp_ch    = smp_valid ? head[ENT_W-1:8]   : '0;

    // ------------------------------------------------------------------
    // Sticky flags: a set event in the same cycle as clr_err wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100M or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overflow    <= ovf_set     || (overflow    && !clr_err);
            timeout_err <= timeout_set || (timeout_err && !clr_err);
            overrun     <= (tick && busy) || (overrun && !clr_err);
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
module tb_adc_scan_scheduler;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int SETTLE  = 8;
    localparam int TOUT    = 1024;
    localparam int ADC_LAT = 20;

    logic        clk_100M = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  ch_mask = '0;
    logic [15:0] period = 16'd100;
    logic        clr_err = 1'b0;
    logic [1:0]  mux_sel;
    logic        adc_start;
    logic        adc_ready = 1'b0;
    logic [7:0]  adc_data = '0;
    logic        smp_valid;
    logic        smp_ready = 1'b0;
    logic [7:0]  smp_data;
    logic [1:0]  smp_ch;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
    logic        overrun;

    adc_scan_scheduler #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD_W(16),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TOUT), .FIFO_DEPTH(4)
    ) dut (
        .clk_100M(clk_100M), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .period(period), .clr_err(clr_err), .mux_sel(mux_sel), .adc_start(adc_start),
        .adc_ready(adc_ready), .adc_data(adc_data), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .smp_data(smp_data), .smp_ch(smp_ch), .busy(busy),
        .overflow(overflow), .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk_100M = ~clk_100M;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_100M);
        #1;
    endtask

    int cyc = 0;
    always @(posedge clk_100M) cyc <= cyc + 1;

    // ADC model: answers ADC_LAT cycles after adc_start with A0+channel,
    // except for channels flagged in noans. Not reset, so a conversion in
    // flight across a DUT reset still produces a late adc_ready.
    logic [3:0] noans = '0;
    int         adc_cnt = 0;
    logic [1:0] adc_ch = '0;
    always @(negedge clk_100M) begin
        adc_ready = 1'b0;
        if (adc_cnt > 0) begin
            adc_cnt--;
            if (adc_cnt == 0) begin
                adc_ready = 1'b1;
                adc_data  = 8'hA0 + {6'd0, adc_ch};
            end
        end
        if (adc_start && !noans[mux_sel]) begin
            adc_cnt = ADC_LAT;
            adc_ch  = mux_sel;
        end
    end

    // Monitor, sampled late in the low phase when everything is stable.
    int         st_cyc[$];
    logic [1:0] st_ch[$];
    int         st_gap[$];
    logic [9:0] smp_q[$];
    logic [1:0] last_mux = '0;
    logic       last_busy = 1'b0;
    int         last_chg = 0;
    bit         mux2_seen = 0;
    always @(negedge clk_100M) begin
        #3;
        if ((mux_sel != last_mux) || (busy && !last_busy)) last_chg = cyc;
        last_mux  = mux_sel;
        last_busy = busy;
        if (mux_sel == 2'd2) mux2_seen = 1;
        if (adc_start) begin
            st_cyc.push_back(cyc);
            st_ch.push_back(mux_sel);
            st_gap.push_back(cyc - last_chg);
        end
        if (smp_valid && smp_ready) smp_q.push_back({smp_ch, smp_data});
    end

    task automatic do_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        smp_ready = 1'b0;
        clr_err   = 1'b0;
        noans     = '0;
        step(2);
        st_cyc.delete();
        st_ch.delete();
        st_gap.delete();
        smp_q.delete();
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (st_cyc.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, st_cyc.size(), n);
    endtask

    function automatic logic [9:0] smp_of(input logic [1:0] ch);
        return {ch, 8'hA0 + {6'd0, ch}};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_ch[6];
        int tcyc;
        int k;

        // Reset state
        do_reset();
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_adc_start", adc_start, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_smp_data", {smp_ch, smp_data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {overflow, timeout_err, overrun}, 0);

        // 1: normal scanning, mask 1011, period 100
        period = 16'd100; ch_mask = 4'b1011; smp_ready = 1'b1; mux2_seen = 0;
        reset = 1'b1;
        step(1);
        enable = 1'b1;
        wait_starts(6, 400, "t1_starts");
        step(25);
        exp_ch = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        for (int i = 0; i < 6; i++) begin
            chk("t1_start_ch", st_ch[i], exp_ch[i]);
            chk("t1_settle_gap", st_gap[i], SETTLE);
        end
        chk("t1_scan_period", st_cyc[3] - st_cyc[0], 100);
        chk("t1_nsamp", smp_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("t1_sample", smp_q[i], smp_of(exp_ch[i]));
        chk("t1_mux2", mux2_seen, 0);
        chk("t1_flags", {overflow, timeout_err, overrun}, 0);

        // 2: ch1 never answers -> timeout, ch3 still converted, clr_err
        do_reset();
        period = 16'd2000; ch_mask = 4'b1011; smp_ready = 1'b1; noans = 4'b0010;
        reset = 1'b1; enable = 1'b1;
        k = 0;
        while (!timeout_err && k < 4000) begin step(1); k++; end
        tcyc = cyc;
        chk("t2_timeout_set", timeout_err, 1);
        chk("t2_ch1_started", st_ch[1], 1);
        // decided in cycle start+TOUT, flag registered at the end of that cycle
        chk("t2_timeout_lat", tcyc - st_cyc[1], TOUT + 1);
        wait_starts(3, 100, "t2_starts");
        step(25);
        chk("t2_ch3_started", st_ch[2], 3);
        chk("t2_nsamp", smp_q.size(), 2);
        chk("t2_sample0", smp_q[0], smp_of(2'd0));
        chk("t2_sample1", smp_q[1], smp_of(2'd3));
        chk("t2_sticky", timeout_err, 1);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        chk("t2_cleared", timeout_err, 0);

        // 3: no downstream accept for 2 scans of 3 channels
        do_reset();
        period = 16'd200; ch_mask = 4'b0111;
        reset = 1'b1; enable = 1'b1;
        wait_starts(6, 700, "t3_starts");
        step(25);
        chk("t3_overflow", overflow, 1);
        chk("t3_valid", smp_valid, 1);
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        chk("t3_ovf_clr", overflow, 0);
        k = 0;
        while (!adc_ready && k < 300) begin step(1); k++; end
        chk("t3_ready_seen", adc_ready, 1);
        smp_ready = 1'b1;             // pop on the same edge as the push into a full FIFO
        step(70);
        chk("t3_no_overflow", overflow, 0);
        chk("t3_ndrained", smp_q.size(), 7);
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) chk("t3_drain", smp_q[i], smp_of(exp_ch[i]));
        chk("t3_drain_last", smp_q[6], smp_of(2'd2));

        // 4: period 10, scans of ~90 cycles -> overrun
        do_reset();
        period = 16'd10; ch_mask = 4'b0111; smp_ready = 1'b1;
        reset = 1'b1; enable = 1'b1;
        wait_starts(6, 400, "t4_starts");
        step(25);
        chk("t4_overrun", overrun, 1);
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 6; i++) chk("t4_start_ch", st_ch[i], exp_ch[i]);
        chk("t4_scan_gap", st_cyc[3] - st_cyc[2], 40);
        chk("t4_nsamp", smp_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("t4_sample", smp_q[i], smp_of(exp_ch[i]));

        // 5: enable dropped and mask changed mid-scan
        do_reset();
        period = 16'd100; ch_mask = 4'b1011; smp_ready = 1'b1;
        reset = 1'b1; enable = 1'b1;
        wait_starts(1, 200, "t5_first_start");
        enable = 1'b0; ch_mask = 4'b0100;
        k = 0;
        while (busy && k < 200) begin step(1); k++; end
        step(300);
        chk("t5_busy", busy, 0);
        chk("t5_nstarts", st_cyc.size(), 3);
        chk("t5_start_ch2", st_ch[2], 3);
        chk("t5_nsamp", smp_q.size(), 3);
        chk("t5_sample0", smp_q[0], smp_of(2'd0));
        chk("t5_sample1", smp_q[1], smp_of(2'd1));
        chk("t5_sample2", smp_q[2], smp_of(2'd3));
        chk("t5_mux_hold", mux_sel, 3);

        // 6: reset during WAIT_CONV, late adc_ready afterwards
        do_reset();
        period = 16'd100; ch_mask = 4'b0011;
        reset = 1'b1; enable = 1'b1;
        wait_starts(2, 300, "t6_starts");
        step(5);
        chk("t6_fifo_before", smp_valid, 1);
        chk("t6_busy_before", busy, 1);
        enable = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", smp_valid, 0);
        chk("t6_async_mux", mux_sel, 0);
        chk("t6_async_busy", busy, 0);
        step(3);
        reset = 1'b1; smp_ready = 1'b1;
        step(40);
        chk("t6_nsamp", smp_q.size(), 0);
        chk("t6_valid", smp_valid, 0);
        chk("t6_nstarts", st_cyc.size(), 2);
        chk("t6_flags", {overflow, timeout_err, overrun, adc_start}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Multi-channel sampling scheduler that sits in front of the 8-bit ADC control block. On a programmable period it scans the enabled analog-mux channels in ascending order. For each channel it waits a settle time, requests one conversion, and collects the result. Each result is tagged with its channel and buffered in a small FIFO that feeds the downstream stream interface; conversion timeouts, FIFO overflows and period overruns are flagged.

## Interface
- NUM_CH, 4: number of analog-mux channels (2..8)
- CH_W, 2: channel index width, clog2(NUM_CH)
- PERIOD_W, 16: scan-period counter width
- SETTLE_CYCLES, 8: cycles between mux_sel change and adc_start (≥1)
- TIMEOUT_CYCLES, 1024: max cycles waiting for adc_ready after adc_start
- FIFO_DEPTH, 4: sample FIFO depth (power of 2)

Ports:
- clk_100M  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scheduler enable
- ch_mask  in  NUM_CH  per-channel enable, bit i = channel i
- period  in  PERIOD_W  scan-start interval in cycles; 0 treated as 1
- clr_err  in  1  clears sticky flags
- mux_sel  out  CH_W  analog mux channel select
- adc_start  out  1  one-cycle conversion request to ADC control block
- adc_ready  in  1  one-cycle pulse, adc_data valid
- adc_data  in  8  conversion result
- smp_valid  out  1  FIFO head valid
- smp_ready  in  1  downstream accept
- smp_data  out  8  FIFO head sample
- smp_ch  out  CH_W  FIFO head channel tag
- busy  out  1  scan in progress (state not IDLE/WAIT_TICK)
- overflow  out  1  sticky: sample dropped on full FIFO
- timeout_err  out  1  sticky: conversion timed out
- overrun  out  1  sticky: period tick arrived during an active scan

## Operation
- Reset values: all outputs 0; state IDLE; period timer loaded with max(period,1)-1; FIFO empty.
- Period timer:
  - Runs only while enable=1; decrements; tick at 0, then reloads max(period,1)-1.
  - Held at reload value while enable=0.
- FSM states: IDLE, WAIT_TICK, SELECT, START, WAIT_CONV, NEXT.
- IDLE -> WAIT_TICK when enable=1.
- WAIT_TICK:
  - On tick with ch_mask≠0: latch ch_mask into scan_mask, select lowest set bit, go SELECT.
  - Tick with ch_mask=0 is ignored.
  - enable=0 -> IDLE.
- SELECT: drive mux_sel=channel and count SETTLE_CYCLES cycles, then go START.
- START: adc_start=1 for exactly one cycle, then go WAIT_CONV.
- WAIT_CONV:
  - On adc_ready: push {channel, adc_data} into the FIFO, go NEXT.
  - After TIMEOUT_CYCLES cycles without adc_ready: set timeout_err, push nothing, go NEXT.
- NEXT:
  - If a higher set bit remains in scan_mask: select it, go SELECT.
  - Otherwise go WAIT_TICK, or IDLE if enable=0.
- enable=0 mid-scan: the current scan completes; enable is only checked in WAIT_TICK/NEXT.
- Changes to ch_mask mid-scan do not affect the current scan.
- adc_ready outside WAIT_CONV is ignored.
- Tick while busy=1: set overrun; the tick is discarded, with no queued scan.
- FIFO (show-ahead):
  - smp_data/smp_ch reflect the head whenever smp_valid=1; pop on smp_valid&smp_ready.
  - Push when full with no pop in the same cycle: sample dropped, overflow set.
  - Push when full with a pop in the same cycle: both occur, no overflow.
- clr_err clears all sticky flags; a set event in the same cycle wins.
- mux_sel holds its last value between scans.

## Timing
- Tick in WAIT_TICK at cycle t:
  - mux_sel valid at t+1.
  - adc_start high at cycle t+1+SETTLE_CYCLES.
- adc_ready at cycle r with an empty FIFO: smp_valid=1 at r+1.
- Next channel's mux_sel at r+2; next adc_start at r+2+SETTLE_CYCLES.
- Timeout: declared TIMEOUT_CYCLES cycles after the adc_start cycle.
- Reset assertion is asynchronous and immediate:
  - Any in-flight conversion is abandoned and FIFO contents are lost.
  - A late adc_ready after reset is ignored (state IDLE).

## Test plan
- Reset, enable=1, period=100, ch_mask=4'b1011, ADC model answers 20 cycles after adc_start with data 8'hA0+ch. Required: one scan per 100 cycles; samples ch0=A0, ch1=A1, ch3=A3 in order; mux_sel never 2; adc_start spaced exactly SETTLE_CYCLES after each mux_sel change.
- ADC model never answers on ch1. Required: timeout_err set 1024 cycles after that adc_start; ch3 still converted; no ch1 sample in FIFO; clr_err clears the flag.
- smp_ready=0, 2 scans of 3 channels. Required: first 4 samples retained; 2 dropped; overflow=1. Then smp_ready=1 with a push in the same cycle as a full pop: no further overflow.
- period=10 with 3 channels, each taking ~30 cycles. Required: overrun=1; scans start only from WAIT_TICK; no interleaved channels.
- enable dropped mid-scan, and ch_mask changed mid-scan. Required: the current scan completes with the original mask, then IDLE; busy=0; no further adc_start.
- reset pulsed low during WAIT_CONV, then adc_ready arrives. Required: all outputs 0; FIFO empty; late adc_ready produces no sample.
